uart_rx_frame: RTL and testbench

Asynchronous serial receiver for the 8N1 frames our transmit blocks emit: start bit 0, 8 data bits LSB first, stop bit 1, no parity. It oversamples the line, assembles up to BYTES bytes per packet, and presents each byte with its index in the packet. It sits on the RS485 receive side of a link, feeding a packet buffer or register file, and flags the last byte of a packet and any framing faults.

---
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 oversampling serial receiver that assembles bytes into
// packets of BYTES bytes and tags each byte with its index in the packet.
// Ports: clk, reset (async, active-low), rx (serial line, idle high);
//        data/addr (last good byte and its index), valid/done/frameErr strobes.
module uart_rx_frame #(
  parameter int BYTES      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int GAP_BITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic [4:0] addr,
  output logic       valid,
  output logic       done,
  output logic       frameErr
);

  localparam int CW      = $clog2(OVERSAMPLE);
  localparam int GAP_LIM = GAP_BITS * OVERSAMPLE;
  localparam int IW      = $clog2(GAP_LIM + 1);

  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] C_GAP  = IW'(GAP_LIM);
  localparam logic [4:0]    C_LAST = 5'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic [4:0]    r_idx, w_idx;
  logic [IW-1:0] r_idle, w_idle;
  logic [7:0]    r_data, w_data;
  logic [4:0]    r_addr, w_addr;
  logic          r_valid, w_valid;
  logic          r_done, w_done;
  logic          r_ferr, w_ferr;
  logic          w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_idle  <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sync  <= {r_sync[0], rx};
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_idx   <= w_idx;
      r_idle  <= w_idle;
      r_data  <= w_data;
      r_addr  <= w_addr;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = '0;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_idx   = r_idx;
    w_idle  = r_idle;
    w_data  = r_data;
    w_addr  = r_addr;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state = S_START;
          w_bit   = '0;
          w_idle  = '0;
        end else if (r_idx != 5'd0) begin
          // Idle too long mid-packet: drop the partial packet quietly.
          if (r_idle == C_GAP) begin
            w_idx = '0;
          end else begin
            w_idle = r_idle + IW'(1);
          end
        end
      end
      S_START: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_HALF) begin
          w_cnt   = '0;
          w_state = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_FULL) begin
          w_cnt   = '0;
          w_shift = {w_rxs, r_shift[7:1]};
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == C_FULL) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_data  = r_shift;
            w_addr  = r_idx;
            w_valid = 1'b1;
            if (r_idx == C_LAST) begin
              w_done = 1'b1;
              w_idx  = '0;
            end else begin
              w_idx = r_idx + 5'd1;
            end
            // Back to IDLE mid stop bit so a following start is not missed.
            w_state = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_idx   = '0;
            w_state = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rxs) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign data     = r_data;
  assign addr     = r_addr;
  assign valid    = r_valid;
  assign done     = r_done;
  assign frameErr = r_ferr;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and random 8N1 frames against a packet-level
// reference model; strobes are collected and compared event by event.
module tb_uart_rx_frame;

  localparam int BYTES = 8;
  localparam int OS    = 16;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic [4:0] addr;
  logic       valid;
  logic       done;
  logic       frameErr;

  uart_rx_frame #(
    .BYTES(BYTES),
    .OVERSAMPLE(OS),
    .GAP_BITS(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data(data),
    .addr(addr),
    .valid(valid),
    .done(done),
    .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] d;
    logic [4:0] a;
    logic       dn;
    int         cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  int  viol = 0;

  always @(negedge clk) begin
    if (valid && frameErr) viol++;
    if (done && !valid) viol++;
    if (valid || frameErr) begin
      mon_e.ferr = frameErr;
      mon_e.d    = data;
      mon_e.a    = addr;
      mon_e.dn   = done;
      mon_e.cyc  = cyc;
      obs_q.push_back(mon_e);
    end
  end

  int checks = 0;
  int errors = 0;
  int m_idx = 0;
  logic [7:0] m_data = 8'h00;
  logic [4:0] m_addr = 5'd0;
  int t_start = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic stopv);
    tick(1);
    rx = 1'b0;
    t_start = cyc;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(OS);
    end
    rx = stopv;
    tick(OS);
    rx = 1'b1;
  endtask

  task automatic idle_bits(int n);
    rx = 1'b1;
    tick(n * OS);
    if (n > GAP) m_idx = 0;
  endtask

  task automatic model_good(logic [7:0] b);
    ev_t e;
    e.ferr = 1'b0;
    e.d    = b;
    e.a    = 5'(m_idx);
    e.dn   = (m_idx == BYTES - 1);
    e.cyc  = 0;
    exp_q.push_back(e);
    m_data = b;
    m_addr = 5'(m_idx);
    m_idx  = (m_idx == BYTES - 1) ? 0 : m_idx + 1;
  endtask

  task automatic model_bad();
    ev_t e;
    e.ferr = 1'b1;
    e.d    = m_data;
    e.a    = m_addr;
    e.dn   = 1'b0;
    e.cyc  = 0;
    exp_q.push_back(e);
    m_idx = 0;
  endtask

  task automatic compare(string tag);
    int n;
    tick(2);
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".ferr"}, obs_q[i].ferr, exp_q[i].ferr);
      check({tag, ".data"}, obs_q[i].d, exp_q[i].d);
      check({tag, ".addr"}, obs_q[i].a, exp_q[i].a);
      check({tag, ".done"}, obs_q[i].dn, exp_q[i].dn);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    bit bad;
    int g;

    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst.data", data, 8'h00);
    check("rst.addr", addr, 5'd0);
    check("rst.valid", valid, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.ferr", frameErr, 1'b0);

    send(8'hA5, 1'b1);
    model_good(8'hA5);
    if (obs_q.size() > 0)
      check("a5.latency", obs_q[0].cyc - t_start, 2 + OS / 2 + 9 * OS + 1);
    compare("single");

    tick(1);
    rx = 1'b0;
    tick(3 * OS);
    reset = 1'b0;
    rx = 1'b1;
    tick(3);
    reset = 1'b1;
    m_idx = 0;
    m_data = 8'h00;
    m_addr = 5'd0;
    tick(2);
    check("midrst.data", data, 8'h00);
    send(8'h3C, 1'b1);
    model_good(8'h3C);
    compare("midrst");

    idle_bits(6);
    for (int k = 1; k <= 9; k++) begin
      send(8'(k), 1'b1);
      model_good(8'(k));
    end
    compare("packet");

    tick(1);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * OS);
    compare("glitch");

    send(8'h55, 1'b0);
    model_bad();
    idle_bits(1);
    send(8'hC3, 1'b1);
    model_good(8'hC3);
    compare("stoperr");

    tick(1);
    rx = 1'b0;
    tick(100 * OS);
    rx = 1'b1;
    model_bad();
    idle_bits(1);
    compare("break");

    for (int k = 0; k < 3; k++) begin
      send(8'(8'h10 + k), 1'b1);
      model_good(8'(8'h10 + k));
    end
    idle_bits(5);
    send(8'h77, 1'b1);
    model_good(8'h77);
    compare("gap");

    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send(b, !bad);
      if (bad) model_bad();
      else model_good(b);
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 6))
                                      : int'($urandom_range(0, 1));
      if (g > 0) idle_bits(g);
    end
    compare("random");

    check("strobe.rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
